puf_crp_controller: RTL

PUF_CRP_CONTROLLER -- requirements
Module: puf_crp_controller

---
 rtl/puf_crp_controller_pkg.sv | 24 ++
 rtl/puf_chal_lfsr.sv | 24 ++
 rtl/puf_crp_controller.sv | 129 ++++++++++++
 3 files changed

// File: rtl/puf_crp_controller_pkg.sv
// Shared types and constants for the arbiter-PUF challenge/response controller.
// Holds the FSM encoding, challenge LFSR geometry and its single-step function.
package puf_crp_controller_pkg;

    localparam int unsigned LFSR_W = 32;

    // Galois form of x^32 + x^22 + x^2 + x + 1, right-shifting.
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;
    localparam logic [LFSR_W-1:0] LFSR_RESET    = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        SAMPLE,
        OUTPUT
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/puf_chal_lfsr.sv
// Challenge generator: 32-bit Galois LFSR with seed load and single-step advance.
// An all-zero seed would lock the register, so it is replaced on load.
module puf_chal_lfsr
    import puf_crp_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_RESET;
        end else if (load) begin
            value <= (seed == '0) ? ZERO_SEED_SUB : seed;
        end else if (step) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/puf_crp_controller.sv
// Drives an arbiter PUF one challenge per bit and packs the synchronised
// responses MSB-first into a RESP_W word, released with a valid/ready handshake.
module puf_crp_controller
    import puf_crp_controller_pkg::*;
#(
    parameter int unsigned RESP_W = 16,
    parameter int unsigned SETTLE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic [31:0]       Chal,
    output logic              in_X,
    output logic              in_Y,
    input  logic              out_Q,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_valid,
    input  logic              resp_ready
);

    localparam int unsigned CNT_W    = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int unsigned SETTLE_W = $clog2(SETTLE);

    state_t state, state_nxt;

    logic [CNT_W-1:0]    bit_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [RESP_W-1:0]   shreg;
    logic [LFSR_W-1:0]   lfsr_value;

    (* keep = "true", async_reg = "true" *) logic sync_q1;
    (* keep = "true", async_reg = "true" *) logic sync_q2;

    logic accept;
    logic last_bit;
    logic settle_done;

    assign accept      = (state == IDLE) && start;
    assign last_bit    = (bit_cnt == CNT_W'(RESP_W - 1));
    assign settle_done = (settle_cnt == SETTLE_W'(SETTLE - 1));

    puf_chal_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  ((state == SAMPLE) && !last_bit),
        .seed  (seed),
        .value (lfsr_value)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)       state_nxt = LOAD;
            LOAD:                     state_nxt = LAUNCH;
            LAUNCH:  if (settle_done) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_bit ? OUTPUT : LOAD;
            OUTPUT:  if (resp_ready)  state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Output logic: all outputs decode from state so reset clears them immediately
    always_comb begin
        busy       = (state != IDLE);
        in_X       = (state == LAUNCH);
        in_Y       = (state == LAUNCH);
        Chal       = '0;
        resp_valid = (state == OUTPUT);
        resp_data  = '0;
        if (state == LOAD || state == LAUNCH || state == SAMPLE) begin
            Chal = lfsr_value;
        end
        if (state == OUTPUT) begin
            resp_data = shreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= out_Q;
            sync_q2 <= sync_q1;
        end
    end

    // LAUNCH cycle counter restarts whenever the launch edge is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == LAUNCH) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (accept) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (state == SAMPLE) begin
                shreg <= (shreg << 1) | RESP_W'(sync_q2);
                if (!last_bit) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
